// File: rtl/proc_port_bridge.sv
// proc_port_bridge
//   Couples the generated processor's port interface to streaming fabric.
//   Input side: an upstream valid/ready stream fills a first-word-fall-through
//   FIFO whose head is presented on processor input port 0.
//   Output side: writes to output port OUT_ADDR are captured into a second
//   FWFT FIFO that a downstream valid/ready stream drains.
//
// Handshake rule (both streams): a word transfers on a rising edge where
// valid and ready are both 1. valid never depends on ready and ready never
// depends on valid. The processor side has no handshake: a read request
// with the input FIFO empty, or a capture into a full output FIFO, is
// reported through sticky flags rather than stalled.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   s_data/s_valid/s_ready          upstream sample stream
//   proc_io_in, proc_req_in         processor input port 0 (head, read strobe)
//   proc_io_out, proc_out_en        processor output data and port select
//   m_data/m_valid/m_ready          downstream sample stream
//   in_level, out_level             registered FIFO occupancies
//   underflow, overflow, clr_flags  sticky error flags and their clear
module proc_port_bridge #(
  parameter int DW        = 32,
  parameter int IN_DEPTH  = 16,
  parameter int OUT_DEPTH = 16,
  parameter int OUT_EN_W  = 7,
  parameter int OUT_ADDR  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DW-1:0]                 s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [DW-1:0]                 proc_io_in,
  input  logic                          proc_req_in,
  input  logic [DW-1:0]                 proc_io_out,
  input  logic [OUT_EN_W-1:0]           proc_out_en,
  output logic [DW-1:0]                 m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(IN_DEPTH):0]     in_level,
  output logic [$clog2(OUT_DEPTH):0]    out_level,
  output logic                          underflow,
  output logic                          overflow,
  input  logic                          clr_flags
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [DW-1:0] r_in_mem [IN_DEPTH];
  logic [IAW:0]  r_in_wr;
  logic [IAW:0]  r_in_rd;
  logic [IAW:0]  r_in_level;
  logic [DW-1:0] r_in_hold;   // last word handed to the processor

  logic          w_in_empty;
  logic          w_in_full;
  logic          w_in_push;
  logic          w_in_pop;
  logic          w_uf_set;
  logic [DW-1:0] w_in_head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_in_empty = (r_in_wr == r_in_rd);
  assign w_in_full  = (r_in_wr[IAW] != r_in_rd[IAW]) &&
                      (r_in_wr[IAW-1:0] == r_in_rd[IAW-1:0]);

  assign w_in_push  = s_valid & ~w_in_full;
  assign w_in_pop   = proc_req_in & ~w_in_empty;
  // A request against an empty FIFO is not a pop, even if a push lands in
  // the same edge: the pushed word only becomes the head afterwards.
  assign w_uf_set   = proc_req_in & w_in_empty;

  assign w_in_head  = r_in_mem[r_in_rd[IAW-1:0]];

  // The processor samples this at the request edge (zero-latency read).
  // When empty, keep showing the last word it consumed.
  assign proc_io_in = w_in_empty ? r_in_hold : w_in_head;
  assign s_ready    = ~w_in_full;
  assign in_level   = r_in_level;

  always_ff @(posedge clk) begin
    if (!rst && w_in_push) begin
      r_in_mem[r_in_wr[IAW-1:0]] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_wr    <= '0;
      r_in_rd    <= '0;
      r_in_level <= '0;
      r_in_hold  <= '0;
    end else begin
      if (w_in_push) begin
        r_in_wr <= r_in_wr + (IAW+1)'(1);
      end
      if (w_in_pop) begin
        r_in_rd   <= r_in_rd + (IAW+1)'(1);
        r_in_hold <= w_in_head;
      end
      case ({w_in_push, w_in_pop})
        2'b10:   r_in_level <= r_in_level + (IAW+1)'(1);
        2'b01:   r_in_level <= r_in_level - (IAW+1)'(1);
        default: r_in_level <= r_in_level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [DW-1:0] r_out_mem [OUT_DEPTH];
  logic [OAW:0]  r_out_wr;
  logic [OAW:0]  r_out_rd;
  logic [OAW:0]  r_out_level;
  logic [DW-1:0] r_out_hold;  // last word drained downstream

  logic          w_out_empty;
  logic          w_out_full;
  logic          w_cap;
  logic          w_out_push;
  logic          w_out_pop;
  logic          w_of_set;
  logic [DW-1:0] w_out_head;

  assign w_out_empty = (r_out_wr == r_out_rd);
  assign w_out_full  = (r_out_wr[OAW] != r_out_rd[OAW]) &&
                       (r_out_wr[OAW-1:0] == r_out_rd[OAW-1:0]);

  assign w_cap       = (proc_out_en == OUT_EN_W'(OUT_ADDR));
  assign w_out_pop   = m_ready & ~w_out_empty;
  // A drain in the same edge frees the slot the capture needs. The write
  // then targets the very slot being read, which is safe because the head
  // is read combinationally before the edge commits the new word.
  assign w_out_push  = w_cap & (~w_out_full | w_out_pop);
  assign w_of_set    = w_cap & w_out_full & ~w_out_pop;

  assign w_out_head  = r_out_mem[r_out_rd[OAW-1:0]];

  assign m_data      = w_out_empty ? r_out_hold : w_out_head;
  assign m_valid     = ~w_out_empty;
  assign out_level   = r_out_level;

  always_ff @(posedge clk) begin
    if (!rst && w_out_push) begin
      r_out_mem[r_out_wr[OAW-1:0]] <= proc_io_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_wr    <= '0;
      r_out_rd    <= '0;
      r_out_level <= '0;
      r_out_hold  <= '0;
    end else begin
      if (w_out_push) begin
        r_out_wr <= r_out_wr + (OAW+1)'(1);
      end
      if (w_out_pop) begin
        r_out_rd   <= r_out_rd + (OAW+1)'(1);
        r_out_hold <= w_out_head;
      end
      case ({w_out_push, w_out_pop})
        2'b10:   r_out_level <= r_out_level + (OAW+1)'(1);
        2'b01:   r_out_level <= r_out_level - (OAW+1)'(1);
        default: r_out_level <= r_out_level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky flags: a set event beats a simultaneous clear.
  // ---------------------------------------------------------------------------
  logic r_underflow;
  logic r_overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_uf_set) begin
        r_underflow <= 1'b1;
      end else if (clr_flags) begin
        r_underflow <= 1'b0;
      end
      if (w_of_set) begin
        r_overflow <= 1'b1;
      end else if (clr_flags) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign underflow = r_underflow;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_proc_port_bridge.sv
module tb_proc_port_bridge;

  localparam int DW = 32;
  localparam int ID = 16;
  localparam int OD = 16;
  localparam int EW = 7;
  localparam logic [DW-1:0] V_M3  = 32'hFFFF_FFFD;  // -3
  localparam logic [DW-1:0] V_M40 = 32'hFFFF_FFD8;  // -40

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] proc_io_in;
  logic          proc_req_in = 1'b0;
  logic [DW-1:0] proc_io_out = '0;
  logic [EW-1:0] proc_out_en = '0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [4:0]    in_level;
  logic [4:0]    out_level;
  logic          underflow;
  logic          overflow;
  logic          clr_flags = 1'b0;

  always #5 clk = ~clk;

  proc_port_bridge #(
    .DW(DW), .IN_DEPTH(ID), .OUT_DEPTH(OD), .OUT_EN_W(EW), .OUT_ADDR(2)
  ) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .proc_io_in(proc_io_in), .proc_req_in(proc_req_in),
    .proc_io_out(proc_io_out), .proc_out_en(proc_out_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .in_level(in_level), .out_level(out_level),
    .underflow(underflow), .overflow(overflow), .clr_flags(clr_flags)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (queues) ----------------
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] out_q[$];
  logic [DW-1:0] drained[$];
  logic [DW-1:0] md_in_hold  = '0;
  logic [DW-1:0] md_out_hold = '0;
  bit            md_uf = 1'b0;
  bit            md_of = 1'b0;

  initial begin
    int  ni;
    int  no;
    bit  uf_ev;
    bit  of_ev;
    bit  opop;
    forever begin
      @(posedge clk);
      if (rst) begin
        in_q.delete();
        out_q.delete();
        md_in_hold  = '0;
        md_out_hold = '0;
        md_uf = 1'b0;
        md_of = 1'b0;
      end else begin
        ni    = in_q.size();
        no    = out_q.size();
        uf_ev = proc_req_in && (ni == 0);
        if (proc_req_in && ni > 0) md_in_hold = in_q.pop_front();
        if (s_valid && ni < ID) in_q.push_back(s_data);
        opop  = m_ready && (no > 0);
        if (opop) md_out_hold = out_q.pop_front();
        of_ev = 1'b0;
        if (proc_out_en == 7'd2) begin
          if (no < OD || opop) out_q.push_back(proc_io_out);
          else of_ev = 1'b1;
        end
        if (uf_ev) md_uf = 1'b1; else if (clr_flags) md_uf = 1'b0;
        if (of_ev) md_of = 1'b1; else if (clr_flags) md_of = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare (opposite edge) ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("s_ready",    32'(s_ready),   32'(in_q.size() < ID));
      check("in_level",   32'(in_level),  32'(in_q.size()));
      check("proc_io_in", proc_io_in,     (in_q.size() > 0) ? in_q[0] : md_in_hold);
      check("m_valid",    32'(m_valid),   32'(out_q.size() > 0));
      check("out_level",  32'(out_level), 32'(out_q.size()));
      check("underflow",  32'(underflow), 32'(md_uf));
      check("overflow",   32'(overflow),  32'(md_of));
      if (out_q.size() > 0) check("m_data", m_data, out_q[0]);
      if (m_valid && m_ready) drained.push_back(m_data);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [EW-1:0] dec_en  [4] = '{7'd1, 7'd2, 7'd3, 7'd2};
  logic [DW-1:0] dec_dat [4] = '{32'd10, 32'd20, 32'd30, V_M40};

  // ---------------- directed stimulus ----------------
  initial begin
    // reset then idle
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_s_ready",   32'(s_ready),   32'd1);
    check("rst_m_valid",   32'(m_valid),   32'd0);
    check("rst_in_level",  32'(in_level),  32'd0);
    check("rst_out_level", 32'(out_level), 32'd0);
    check("rst_uf",        32'(underflow), 32'd0);
    check("rst_of",        32'(overflow),  32'd0);
    check("rst_pio",       proc_io_in,     32'd0);
    check("rst_m_data",    m_data,         32'd0);
    cyc(1);

    // input stream: 5, -3, 7
    s_valid = 1'b1; s_data = 32'd5; cyc(1);
    s_data = V_M3; cyc(1);
    s_data = 32'd7; cyc(1);
    s_valid = 1'b0;
    check("str_level3", 32'(in_level), 32'd3);
    proc_req_in = 1'b1;
    check("str_head0", proc_io_in, 32'd5); cyc(1);
    check("str_head1", proc_io_in, V_M3);  cyc(1);
    check("str_head2", proc_io_in, 32'd7); cyc(1);
    proc_req_in = 1'b0;
    check("str_level0", 32'(in_level), 32'd0);
    check("str_uf",     32'(underflow), 32'd0);
    check("str_hold",   proc_io_in, 32'd7);

    // input boundaries: fill, refused 17th, drain, underflow
    s_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_data = 32'(100 + i);
      cyc(1);
    end
    check("full_s_ready", 32'(s_ready),  32'd0);
    check("full_level",   32'(in_level), 32'd16);
    s_data = 32'd999; cyc(1);
    s_valid = 1'b0;
    check("full_refuse",  32'(in_level), 32'd16);
    proc_req_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("full_head", proc_io_in, 32'(100 + i));
      cyc(1);
    end
    cyc(1);  // request on empty FIFO
    proc_req_in = 1'b0;
    check("uf_set",  32'(underflow), 32'd1);
    check("uf_hold", proc_io_in, 32'd115);
    proc_req_in = 1'b1; clr_flags = 1'b1; cyc(1);
    check("uf_set_wins", 32'(underflow), 32'd1);
    proc_req_in = 1'b0; cyc(1);
    clr_flags = 1'b0;
    check("uf_clr", 32'(underflow), 32'd0);
    // push + request on empty: underflow, word visible next cycle
    s_valid = 1'b1; s_data = 32'd42; proc_req_in = 1'b1; cyc(1);
    s_valid = 1'b0; proc_req_in = 1'b0;
    check("pp_empty_uf",    32'(underflow), 32'd1);
    check("pp_empty_level", 32'(in_level),  32'd1);
    check("pp_empty_head",  proc_io_in,     32'd42);
    // push + pop with one entry: level unchanged
    s_valid = 1'b1; s_data = 32'd43; proc_req_in = 1'b1; cyc(1);
    s_valid = 1'b0;
    check("pp_mid_level", 32'(in_level), 32'd1);
    check("pp_mid_head",  proc_io_in,    32'd43);
    cyc(1);
    proc_req_in = 1'b0;
    clr_flags = 1'b1; cyc(1); clr_flags = 1'b0;

    // output decode
    drained.delete();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      proc_out_en = dec_en[i];
      proc_io_out = dec_dat[i];
      cyc(1);
    end
    proc_out_en = '0;
    cyc(3);
    check("dec_count", 32'(drained.size()), 32'd2);
    if (drained.size() == 2) begin
      check("dec_w0", drained[0], 32'd20);
      check("dec_w1", drained[1], V_M40);
    end

    // output full: 17 writes with no drain
    drained.delete();
    m_ready = 1'b0;
    proc_out_en = 7'd2;
    for (int i = 0; i < 17; i++) begin
      proc_io_out = 32'(200 + i);
      cyc(1);
    end
    proc_out_en = '0;
    check("ofull_level", 32'(out_level), 32'd16);
    check("ofull_of",    32'(overflow),  32'd1);
    m_ready = 1'b1; cyc(18); m_ready = 1'b0;
    check("ofull_count", 32'(drained.size()), 32'd16);
    if (drained.size() == 16) check("ofull_last", drained[15], 32'd215);
    clr_flags = 1'b1; cyc(1); clr_flags = 1'b0;

    // full with a drain on the 17th write: no overflow
    drained.delete();
    proc_out_en = 7'd2;
    for (int i = 0; i < 16; i++) begin
      proc_io_out = 32'(300 + i);
      cyc(1);
    end
    m_ready = 1'b1; proc_io_out = 32'd316; cyc(1);
    proc_out_en = '0; m_ready = 1'b0;
    check("ofree_of",    32'(overflow),  32'd0);
    check("ofree_level", 32'(out_level), 32'd16);
    m_ready = 1'b1; cyc(18); m_ready = 1'b0;
    check("ofree_count", 32'(drained.size()), 32'd17);
    if (drained.size() == 17) begin
      check("ofree_first", drained[0],  32'd300);
      check("ofree_last",  drained[16], 32'd316);
    end

    // reset mid-operation
    proc_req_in = 1'b1; cyc(1); proc_req_in = 1'b0;
    s_valid = 1'b1; proc_out_en = 7'd2;
    for (int i = 0; i < 4; i++) begin
      s_data = 32'(500 + i);
      proc_io_out = 32'(600 + i);
      cyc(1);
    end
    s_valid = 1'b0; proc_out_en = '0;
    check("mid_in_level",  32'(in_level),  32'd4);
    check("mid_out_level", 32'(out_level), 32'd4);
    check("mid_uf",        32'(underflow), 32'd1);
    rst = 1'b1; cyc(1); rst = 1'b0;
    check("mrst_in_level",  32'(in_level),  32'd0);
    check("mrst_out_level", 32'(out_level), 32'd0);
    check("mrst_m_valid",   32'(m_valid),   32'd0);
    check("mrst_uf",        32'(underflow), 32'd0);
    check("mrst_of",        32'(overflow),  32'd0);
    check("mrst_s_ready",   32'(s_ready),   32'd1);
    check("mrst_pio",       proc_io_in,     32'd0);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
